// File: rtl/ip_pkg.sv
// Shared kernel-interface constants and pixel type; no logic, no latency.
package ip_pkg;
    localparam int DEF_PIX_W = 4;
    localparam int KSZ       = 3;

    typedef logic [DEF_PIX_W-1:0] pix_t;
endpackage

// File: rtl/line_buffer.sv
// One image line of pixels: write on the clock edge, read combinationally.
// Zero-cycle read latency; no flow control of its own, the caller gates writes.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Read is taken before the same-edge write, so rdata is the previous line's pixel.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 windows; window valid one cycle after its last pixel is accepted.
// Single output stage: in_ready = !out_valid || out_ready, so a stalled window freezes all state.
module window_gen_3x3
    import ip_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = DEF_PIX_W,
    localparam int XW   = $clog2(IMG_W),
    localparam int YW   = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_win [KSZ][KSZ],
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             out_last
);
    logic [XW-1:0]    col;
    logic [YW-1:0]    row;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic             accept;
    logic             emit;
    logic             col_end;
    logic             row_end;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == XW'(IMG_W - 1));
    assign row_end  = (row == YW'(IMG_H - 1));
    assign emit     = (row >= YW'(2)) && (col >= XW'(2));

    // lb0 holds the line above the current one, lb1 the line above that.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (in_pix),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            col       <= '0;
            row       <= '0;
            for (int r = 0; r < KSZ; r++) begin
                for (int c = 0; c < KSZ; c++) begin
                    out_win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int k = 0; k < KSZ; k++) begin
                out_win[k][0] <= out_win[k][1];
                out_win[k][1] <= out_win[k][2];
            end
            out_win[0][2] <= lb1_rd;
            out_win[1][2] <= lb0_rd;
            out_win[2][2] <= in_pix;
            out_valid     <= emit;
            out_last      <= emit && row_end && col_end;
            if (emit) begin
                out_x <= col - XW'(1);
                out_y <= row - YW'(1);
            end
            // Border columns/rows still shift through the window but never emit.
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
endmodule
